// File: rtl/key_action_mapper.sv
// Maps decoded PS/2 key events onto NUM_KEYS programmable key channels.
// Each channel provides held/press/release levels and game-style auto-repeat.
module key_action_mapper #(
    parameter int NUM_KEYS     = 5,
    parameter int CODE_W       = 9,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000,
    parameter int CNT_W        = 25,
    parameter int IDX_W        = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_KEYS*CODE_W-1:0] key_map,
    input  logic [1:0]                 mode,
    input  logic                       clear,
    input  logic                       ev_valid,
    input  logic [CODE_W-1:0]          ev_code,
    input  logic                       ev_break,
    output logic [NUM_KEYS-1:0]        held,
    output logic [NUM_KEYS-1:0]        press_pulse,
    output logic [NUM_KEYS-1:0]        release_pulse,
    output logic [NUM_KEYS-1:0]        act,
    output logic [IDX_W-1:0]           last_idx,
    output logic                       last_valid
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LOAD  = CNT_W'(REPEAT_RATE - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};

    state_t              r_state [NUM_KEYS];
    logic [CNT_W-1:0]    r_cnt   [NUM_KEYS];
    logic [NUM_KEYS-1:0] r_held;
    logic [NUM_KEYS-1:0] r_press;
    logic [NUM_KEYS-1:0] r_release;
    logic [NUM_KEYS-1:0] r_rep;
    logic [IDX_W-1:0]    r_last_idx;
    logic                r_last_valid;
    logic                r_arm;

    logic [NUM_KEYS-1:0] w_match;
    logic [NUM_KEYS-1:0] w_key_make;
    logic [NUM_KEYS-1:0] w_key_break;
    logic [NUM_KEYS-1:0] w_leave_idle;
    logic [NUM_KEYS-1:0] w_act;
    logic [IDX_W-1:0]    w_hit_idx;
    logic                w_hit;
    logic                w_ev_ok;
    logic                w_break_last;

    // r_arm blocks events on the first edge after reset release
    assign w_ev_ok = r_arm & ev_valid;
    assign w_hit   = |w_match;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        assign w_match[g]      = (key_map[g*CODE_W +: CODE_W] == ev_code);
        assign w_key_make[g]   = w_ev_ok & w_hit & (w_hit_idx == IDX_W'(g)) & ~ev_break;
        assign w_key_break[g]  = w_ev_ok & w_hit & (w_hit_idx == IDX_W'(g)) & ev_break;
        assign w_leave_idle[g] = w_key_make[g] & (r_state[g] == ST_IDLE);
    end

    assign w_break_last = w_ev_ok & w_hit & ev_break & (w_hit_idx == r_last_idx);

    // Lowest matching slot wins when key_map has duplicate codes
    always_comb begin
        w_hit_idx = {IDX_W{1'b0}};
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            w_hit_idx = w_match[i] ? IDX_W'(i) : w_hit_idx;
        end
    end

    // Per-key FSMs, repeat counters, pulses and last-key tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                r_state[i] <= ST_IDLE;
                r_cnt[i]   <= CNT_ZERO;
            end
            r_held       <= {NUM_KEYS{1'b0}};
            r_press      <= {NUM_KEYS{1'b0}};
            r_release    <= {NUM_KEYS{1'b0}};
            r_rep        <= {NUM_KEYS{1'b0}};
            r_last_idx   <= {IDX_W{1'b0}};
            r_last_valid <= 1'b0;
            r_arm        <= 1'b0;
        end else begin
            r_arm <= 1'b1;
            if (clear) begin
                for (int i = 0; i < NUM_KEYS; i++) begin
                    r_state[i] <= ST_IDLE;
                    r_cnt[i]   <= CNT_ZERO;
                end
                r_held       <= {NUM_KEYS{1'b0}};
                r_press      <= {NUM_KEYS{1'b0}};
                r_release    <= {NUM_KEYS{1'b0}};
                r_rep        <= {NUM_KEYS{1'b0}};
                r_last_idx   <= {IDX_W{1'b0}};
                r_last_valid <= 1'b0;
            end else begin
                for (int i = 0; i < NUM_KEYS; i++) begin
                    r_press[i]   <= 1'b0;
                    r_release[i] <= 1'b0;
                    r_rep[i]     <= 1'b0;
                    case (r_state[i])
                        ST_IDLE: begin
                            if (w_key_make[i]) begin
                                r_state[i] <= ST_DELAY;
                                r_held[i]  <= 1'b1;
                                r_press[i] <= 1'b1;
                                r_cnt[i]   <= DELAY_LOAD;
                            end else begin
                                r_cnt[i] <= CNT_ZERO;
                            end
                        end
                        ST_DELAY, ST_REPEAT: begin
                            // A release suppresses any repeat due in the same cycle
                            if (w_key_break[i]) begin
                                r_state[i]   <= ST_IDLE;
                                r_held[i]    <= 1'b0;
                                r_release[i] <= 1'b1;
                                r_cnt[i]     <= CNT_ZERO;
                            end else if (r_cnt[i] == CNT_ZERO) begin
                                r_state[i] <= ST_REPEAT;
                                r_rep[i]   <= 1'b1;
                                r_cnt[i]   <= RATE_LOAD;
                            end else begin
                                r_cnt[i] <= r_cnt[i] - {{(CNT_W-1){1'b0}}, 1'b1};
                            end
                        end
                        default: begin
                            r_state[i] <= ST_IDLE;
                            r_held[i]  <= 1'b0;
                            r_cnt[i]   <= CNT_ZERO;
                        end
                    endcase
                end
                if (|w_leave_idle) begin
                    r_last_idx   <= w_hit_idx;
                    r_last_valid <= 1'b1;
                end else if (w_break_last) begin
                    r_last_valid <= 1'b0;
                end else begin
                    r_last_valid <= r_last_valid;
                end
            end
        end
    end

    // Mode selects which registered per-key signal drives act; mode 3 acts as LEVEL
    always_comb begin
        case (mode)
            2'd1:    w_act = r_press;
            2'd2:    w_act = r_press | r_rep;
            default: w_act = r_held;
        endcase
    end

    assign held          = r_held;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign act           = w_act;
    assign last_idx      = r_last_idx;
    assign last_valid    = r_last_valid;

endmodule

// File: tb/tb_key_action_mapper.sv
// Directed table-driven bench for key_action_mapper with hand-written
// sequences for auto-repeat timing, clear and asynchronous reset.
module tb_key_action_mapper;

    localparam int NK = 5;
    localparam int CW = 9;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NK*CW-1:0] key_map;
    logic [1:0]      mode = 2'd0;
    logic            clear = 1'b0;
    logic            ev_valid = 1'b0;
    logic [CW-1:0]   ev_code = 9'h000;
    logic            ev_break = 1'b0;
    logic [NK-1:0]   held, press_pulse, release_pulse, act;
    logic [2:0]      last_idx;
    logic            last_valid;

    int checks = 0;
    int errors = 0;

    key_action_mapper #(
        .NUM_KEYS(NK), .CODE_W(CW), .REPEAT_DELAY(4), .REPEAT_RATE(2),
        .CNT_W(25), .IDX_W(3)
    ) dut (
        .clk(clk), .rst(rst), .key_map(key_map), .mode(mode), .clear(clear),
        .ev_valid(ev_valid), .ev_code(ev_code), .ev_break(ev_break),
        .held(held), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .act(act), .last_idx(last_idx), .last_valid(last_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        logic       vld;
        logic [8:0] code;
        logic       brk;
        logic [4:0] held;
        logic [4:0] press;
        logic [4:0] rel;
        logic [4:0] act;
        logic [2:0] lidx;
        logic       lvld;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(logic [1:0] m, logic v, logic [8:0] c, logic b,
                                logic [4:0] h, logic [4:0] p, logic [4:0] r,
                                logic [4:0] a, logic [2:0] li, logic lv);
        vec_t t;
        t.mode = m; t.vld = v; t.code = c; t.brk = b;
        t.held = h; t.press = p; t.rel = r; t.act = a; t.lidx = li; t.lvld = lv;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step(input logic [1:0] m, input logic clr, input logic v,
                        input logic [8:0] c, input logic b);
        @(negedge clk);
        mode = m; clear = clr; ev_valid = v; ev_code = c; ev_break = b;
        @(posedge clk);
        #1;
        ev_valid = 1'b0; clear = 1'b0;
    endtask

    task automatic chk_all(input string tag, input logic [4:0] h, input logic [4:0] p,
                           input logic [4:0] r, input logic [4:0] a);
        chk({tag, ".held"}, 32'(held), 32'(h));
        chk({tag, ".press"}, 32'(press_pulse), 32'(p));
        chk({tag, ".release"}, 32'(release_pulse), 32'(r));
        chk({tag, ".act"}, 32'(act), 32'(a));
    endtask

    initial begin
        // slot0=16B slot1=174 slot2=175 slot3=172 slot4=029
        key_map = {9'h029, 9'h172, 9'h175, 9'h174, 9'h16B};

        tbl[0]  = mk(2'd0, 1'b1, 9'h175, 1'b0, 5'b00100, 5'b00100, 5'b00000, 5'b00100, 3'd2, 1'b1);
        tbl[1]  = mk(2'd0, 1'b0, 9'h000, 1'b0, 5'b00100, 5'b00000, 5'b00000, 5'b00100, 3'd2, 1'b1);
        tbl[2]  = mk(2'd0, 1'b1, 9'h175, 1'b1, 5'b00000, 5'b00000, 5'b00100, 5'b00000, 3'd2, 1'b0);
        tbl[3]  = mk(2'd0, 1'b0, 9'h000, 1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 3'd2, 1'b0);
        tbl[4]  = mk(2'd0, 1'b1, 9'h174, 1'b0, 5'b00010, 5'b00010, 5'b00000, 5'b00010, 3'd1, 1'b1);
        tbl[5]  = mk(2'd0, 1'b1, 9'h172, 1'b0, 5'b01010, 5'b01000, 5'b00000, 5'b01010, 3'd3, 1'b1);
        tbl[6]  = mk(2'd0, 1'b1, 9'h174, 1'b0, 5'b01010, 5'b00000, 5'b00000, 5'b01010, 3'd3, 1'b1);
        tbl[7]  = mk(2'd0, 1'b1, 9'h172, 1'b1, 5'b00010, 5'b00000, 5'b01000, 5'b00010, 3'd3, 1'b0);
        tbl[8]  = mk(2'd0, 1'b1, 9'h174, 1'b1, 5'b00000, 5'b00000, 5'b00010, 5'b00000, 3'd3, 1'b0);
        tbl[9]  = mk(2'd0, 1'b1, 9'h01C, 1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 3'd3, 1'b0);
        tbl[10] = mk(2'd0, 1'b1, 9'h01C, 1'b1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 3'd3, 1'b0);
        tbl[11] = mk(2'd0, 1'b1, 9'h175, 1'b1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 3'd3, 1'b0);
        tbl[12] = mk(2'd0, 1'b1, 9'h16B, 1'b0, 5'b00001, 5'b00001, 5'b00000, 5'b00001, 3'd0, 1'b1);
        tbl[13] = mk(2'd0, 1'b1, 9'h029, 1'b0, 5'b10001, 5'b10000, 5'b00000, 5'b10001, 3'd4, 1'b1);
        tbl[14] = mk(2'd0, 1'b1, 9'h16B, 1'b1, 5'b10000, 5'b00000, 5'b00001, 5'b10000, 3'd4, 1'b1);
        tbl[15] = mk(2'd1, 1'b0, 9'h000, 1'b0, 5'b10000, 5'b00000, 5'b00000, 5'b00000, 3'd4, 1'b1);
        tbl[16] = mk(2'd1, 1'b1, 9'h175, 1'b0, 5'b10100, 5'b00100, 5'b00000, 5'b00100, 3'd2, 1'b1);
        tbl[17] = mk(2'd1, 1'b1, 9'h029, 1'b1, 5'b00100, 5'b00000, 5'b10000, 5'b00000, 3'd2, 1'b1);
        tbl[18] = mk(2'd0, 1'b1, 9'h175, 1'b1, 5'b00000, 5'b00000, 5'b00100, 5'b00000, 3'd2, 1'b0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 5'b00000, 5'b00000, 5'b00000, 5'b00000);
        chk("reset.last_valid", 32'(last_valid), 32'd0);
        chk("reset.last_idx", 32'(last_idx), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step(2'd0, 1'b0, 1'b0, 9'h000, 1'b0);

        for (int i = 0; i < 19; i++) begin
            step(tbl[i].mode, 1'b0, tbl[i].vld, tbl[i].code, tbl[i].brk);
            chk_all($sformatf("row%0d", i), tbl[i].held, tbl[i].press, tbl[i].rel, tbl[i].act);
            chk($sformatf("row%0d.last_idx", i), 32'(last_idx), 32'(tbl[i].lidx));
            chk($sformatf("row%0d.last_valid", i), 32'(last_valid), 32'(tbl[i].lvld));
        end

        // Duplicate map: lowest slot wins
        key_map[1*CW +: CW] = 9'h029;
        step(2'd0, 1'b0, 1'b1, 9'h029, 1'b0);
        chk_all("dup.make", 5'b00010, 5'b00010, 5'b00000, 5'b00010);
        step(2'd0, 1'b0, 1'b1, 9'h029, 1'b1);
        chk_all("dup.break", 5'b00000, 5'b00000, 5'b00010, 5'b00000);
        key_map[1*CW +: CW] = 9'h174;

        // Auto-repeat: press at T, reps at T+4, +6, +8, +10
        step(2'd2, 1'b0, 1'b1, 9'h16B, 1'b0);
        chk_all("rep.T", 5'b00001, 5'b00001, 5'b00000, 5'b00001);
        for (int k = 1; k <= 10; k++) begin
            step(2'd2, 1'b0, 1'b0, 9'h000, 1'b0);
            chk($sformatf("rep.T+%0d.act", k), 32'(act),
                (k == 4 || k == 6 || k == 8 || k == 10) ? 32'd1 : 32'd0);
        end
        step(2'd2, 1'b0, 1'b1, 9'h16B, 1'b1);
        chk_all("rep.T+11", 5'b00000, 5'b00000, 5'b00001, 5'b00000);
        for (int k = 12; k <= 15; k++) begin
            step(2'd2, 1'b0, 1'b0, 9'h000, 1'b0);
            chk($sformatf("rep.T+%0d.act", k), 32'(act), 32'd0);
        end

        // clear overrides a same-cycle make
        step(2'd2, 1'b0, 1'b1, 9'h16B, 1'b0);
        step(2'd2, 1'b0, 1'b1, 9'h175, 1'b0);
        step(2'd2, 1'b0, 1'b0, 9'h000, 1'b0);
        chk("clr.pre.held", 32'(held), 32'(5'b00101));
        step(2'd2, 1'b1, 1'b1, 9'h172, 1'b0);
        chk_all("clr", 5'b00000, 5'b00000, 5'b00000, 5'b00000);
        chk("clr.last_valid", 32'(last_valid), 32'd0);
        step(2'd2, 1'b0, 1'b0, 9'h000, 1'b0);
        chk_all("clr.after", 5'b00000, 5'b00000, 5'b00000, 5'b00000);

        // Async reset mid-DELAY, checked between clock edges
        step(2'd0, 1'b0, 1'b1, 9'h16B, 1'b0);
        step(2'd0, 1'b0, 1'b0, 9'h000, 1'b0);
        chk("arst.pre.held", 32'(held), 32'(5'b00001));
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk_all("arst", 5'b00000, 5'b00000, 5'b00000, 5'b00000);
        chk("arst.last_valid", 32'(last_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ev_valid = 1'b1; ev_code = 9'h16B; ev_break = 1'b0;
        @(posedge clk);
        #1;
        ev_valid = 1'b0;
        chk("arst.release_edge.held", 32'(held), 32'd0);
        step(2'd0, 1'b0, 1'b1, 9'h16B, 1'b0);
        chk_all("arst.resume", 5'b00001, 5'b00001, 5'b00000, 5'b00001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_action_mapper.md
Name: key_action_mapper

Overview:
Parametrised successor to the fixed five-key arrow/space signal block. It consumes decoded PS/2 key events (9-bit code {extend, scancode}, make/break, one-cycle valid) and tracks NUM_KEYS runtime-programmable keys independently, so any number of them can be held at once. Per key it produces held levels, press and release pulses, and game-style auto-repeat pulses selected by a mode input. It also reports the most recently pressed key. It sits between the keyboard decoder and game control logic.

Parameters:
NUM_KEYS, 5, number of tracked keys/channels (1..16)
CODE_W, 9, key code width ({extend, scancode[7:0]})
REPEAT_DELAY, 25000000, cycles from press pulse to first repeat pulse (>=1)
REPEAT_RATE, 5000000, cycles between subsequent repeat pulses (>=1)
CNT_W, 25, repeat counter width; must hold max(REPEAT_DELAY, REPEAT_RATE)
IDX_W, 3, index width; must satisfy 2**IDX_W >= NUM_KEYS

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
key_map  in  NUM_KEYS*CODE_W  code of key i in bits [i*CODE_W +: CODE_W]; quasi-static
mode  in  2  0=LEVEL, 1=PULSE, 2=REPEAT, 3=reserved (behaves as LEVEL)
clear  in  1  synchronous flush of all key state
ev_valid  in  1  one-cycle event strobe
ev_code  in  CODE_W  event key code
ev_break  in  1  1=break (release), 0=make (press)
held  out  NUM_KEYS  key i currently down
press_pulse  out  NUM_KEYS  one-cycle pulse on up->down transition
release_pulse  out  NUM_KEYS  one-cycle pulse on down->up transition
act  out  NUM_KEYS  mode-dependent action output
last_idx  out  IDX_W  index of most recently pressed, still-held key
last_valid  out  1  last_idx is meaningful

Behaviour:
- All outputs and internal state are registered. Reset value: every output is 0, all per-key FSMs are IDLE, and all counters are 0.
- Match: an event hits key i when ev_code == key_map slice i. If several slices are equal, only the lowest index is hit. Events that match no slice are ignored.
- Latency: for an event sampled at edge T, held, press_pulse and release_pulse reflect it after edge T. Pulses are high for exactly one cycle.
- Per-key FSM states are IDLE, DELAY and REPEAT.
  - IDLE + make hit: go to DELAY, set held, pulse press_pulse, load cnt = REPEAT_DELAY-1.
  - DELAY: decrement cnt each cycle. When cnt==0, pulse rep, reload cnt = REPEAT_RATE-1, go to REPEAT.
  - REPEAT: decrement cnt each cycle. When cnt==0, pulse rep and reload cnt = REPEAT_RATE-1.
  - DELAY/REPEAT + break hit: go to IDLE, clear held, pulse release_pulse, set cnt=0. No rep is issued in that cycle.
  - Make hit while not IDLE (PS/2 typematic resend) is ignored: no pulse, counter not restarted.
  - Break hit while IDLE is ignored: no release_pulse.
- Net timing: the first rep falls REPEAT_DELAY cycles after press_pulse; later reps follow every REPEAT_RATE cycles.
- act per mode:
  - LEVEL: act = held.
  - PULSE: act = press_pulse.
  - REPEAT: act = press_pulse | rep.
  - mode is combinationally applied to registered signals. Counters run in every mode, so a mode switch does not disturb key state.
- Last key:
  - A make hit that leaves IDLE sets last_idx=i and last_valid=1.
  - A break of key last_idx clears last_valid; last_idx holds its old value.
  - Breaks of other keys do not affect last_idx or last_valid.
- clear (synchronous) has the same effect as reset: all keys go to IDLE and held, act and last_valid go to 0. No release pulses are generated. clear overrides an ev_valid in the same cycle.
- Only one event per cycle is possible. Independent keys run concurrently; each key has its own counter.
- Asserting rst mid-operation immediately zeroes all outputs. Events on the cycle rst deasserts are ignored.

Test Plan:
- NUM_KEYS=5, DELAY=4, RATE=2, mode=LEVEL, key_map slot 2=9'h175. Make 9'h175 -> held=5'b00100 and press_pulse[2] for 1 cycle, act=00100. Break -> held=0, release_pulse[2] 1 cycle, act=0.
- mode=REPEAT, make slot 0 at edge T, held 10 cycles -> act[0] high at T (press), T+4, T+6, T+8, T+10. Break at T+11 -> no further act pulses.
- Make slot 1, make slot 3, make slot 1 again (typematic), break slot 3 -> held 00010, 01010, 01010 (no new pulse), 00010. last_idx=3 after the second make; last_valid=0 after the break of slot 3.
- Unmapped code 9'h01C make and break -> all outputs remain 0. Break on an idle mapped key -> no release_pulse.
- Duplicate map (slots 1 and 4 = 9'h029), make 9'h029 -> only held[1]=1.
- Hold keys 0 and 2 in REPEAT mode. Assert clear (same cycle as an ev_valid make for slot 3) -> all outputs 0 next cycle, slot 3 not held. Then assert async rst mid-DELAY -> outputs 0 without waiting for a clock edge.
